// File: rtl/multi_pwm_fader_pkg.sv
// Shared types, default sizes and the saturating fade-step helper for multi_pwm_fader.
package multi_pwm_fader_pkg;

  localparam int unsigned PWM_WIDTH  = 8;
  localparam int unsigned PWM_NUM_CH = 8;

  typedef logic [PWM_WIDTH-1:0] duty_t;

  // Move cur one step toward tgt, landing exactly on tgt instead of overshooting.
  // Operands are carried at 32 bits so cur + step can never wrap for duty widths up to 31.
  function automatic logic [31:0] step_toward(input logic [31:0] cur,
                                              input logic [31:0] tgt,
                                              input logic [31:0] step);
    logic [31:0] res;
    res = cur;
    if (cur < tgt) begin
      res = ((tgt - cur) <= step) ? tgt : cur + step;
    end else if (cur > tgt) begin
      res = ((cur - tgt) <= step) ? tgt : cur - step;
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_fader_channel.sv
// One PWM channel: target synchroniser with stability filter, faded duty and output compare.
module pwm_fader_channel
  import multi_pwm_fader_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_WIDTH,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] counter,
  input  logic             step_evt,
  output logic             pwm,
  output logic [WIDTH-1:0] cur_duty,
  output logic [WIDTH-1:0] tgt_q
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] s3;

  // Two-flop synchroniser; tgt_q only takes a value that held for two clk cycles,
  // so a multi-bit target caught mid-change never reaches the fade logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      s3    <= '0;
      tgt_q <= '0;
    end else begin
      s1 <= target;
      s2 <= s1;
      s3 <= s2;
      if (s2 == s3) begin
        tgt_q <= s2;
      end
    end
  end

  // Duty moves only on the period boundary; output is high while counter < duty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_duty <= '0;
      pwm      <= 1'b0;
    end else begin
      if (step_evt) begin
        cur_duty <= WIDTH'(step_toward(32'(cur_duty), 32'(tgt_q), 32'(STEP)));
      end
      pwm <= (counter < cur_duty);
    end
  end

endmodule

// File: rtl/multi_pwm_fader.sv
// Multi-channel fading PWM generator sharing one period counter and fade divider.
module multi_pwm_fader
  import multi_pwm_fader_pkg::*;
#(
  parameter int unsigned NUM_CH   = PWM_NUM_CH,
  parameter int unsigned WIDTH    = PWM_WIDTH,
  parameter int unsigned STEP     = 1,
  parameter int unsigned FADE_DIV = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*WIDTH-1:0] target_duty,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_start,
  output logic                    fading
);

  localparam int unsigned     FW        = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [WIDTH-1:0] CNT_LAST = '1;
  localparam logic [FW-1:0]    FADE_LAST = FW'(FADE_DIV - 1);

  logic [WIDTH-1:0]  counter;
  logic [FW-1:0]     fade_cnt;
  logic              wrap;
  logic              step_evt;
  logic [NUM_CH-1:0] differs;

  assign wrap     = (counter == CNT_LAST);
  assign step_evt = wrap && (fade_cnt == FADE_LAST);

  // Free-running period counter and the period divider that paces fade steps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter  <= '0;
      fade_cnt <= '0;
    end else begin
      counter <= counter + WIDTH'(1);
      if (wrap) begin
        fade_cnt <= (fade_cnt == FADE_LAST) ? '0 : fade_cnt + FW'(1);
      end
    end
  end

  // Registered period marker and the any-channel-still-fading flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_start <= 1'b0;
      fading       <= 1'b0;
    end else begin
      period_start <= (counter == '0);
      fading       <= |differs;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] tgt;

    pwm_fader_channel #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .target   (target_duty[i*WIDTH +: WIDTH]),
      .counter  (counter),
      .step_evt (step_evt),
      .pwm      (pwm_out[i]),
      .cur_duty (cur),
      .tgt_q    (tgt)
    );

    assign differs[i] = (cur != tgt);
  end

endmodule
